w5100s_access_arbiter: RTL and testbench

- Round-robin arbiter and transaction sequencer placed in front of the W5100S SPI master.
- Lets NUM_REQ independent clients (socket engines, init sequencer, interrupt poller) share the single SPI master.
- Each client issues one-byte register read/write requests. The block launches one SPI frame per grant, waits for completion, and returns read data plus a one-cycle ack to the granted client.
- A timeout watchdog recovers from a hung transfer.

---
 rtl/w5100s_access_arbiter.sv | 142 ++++++++++++++
 tb/tb_w5100s_access_arbiter.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/w5100s_access_arbiter.sv
// Round-robin arbiter that shares one W5100S SPI master between NUM_REQ clients,
// sequencing one single-byte register frame per grant with a timeout watchdog.
module w5100s_access_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int GUARD_CYCLES   = 2,
    localparam int ID_W          = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_REQ-1:0]    req,
    input  logic [NUM_REQ-1:0]    req_wr,
    input  logic [16*NUM_REQ-1:0] req_addr,
    input  logic [8*NUM_REQ-1:0]  req_wdata,
    output logic [NUM_REQ-1:0]    ack,
    output logic                  err,
    output logic [7:0]            rdata,
    output logic [ID_W-1:0]       grant_id,
    output logic                  spi_start,
    output logic                  spi_write_read,
    output logic [23:0]           spi_data_in,
    input  logic                  spi_busy,
    input  logic                  spi_data_ready,
    input  logic [7:0]            spi_data_out
);

    localparam int TMO_W = $clog2(TIMEOUT_CYCLES);
    localparam int GRD_W = $clog2(GUARD_CYCLES + 2);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_CLR,
        S_WAIT_DONE,
        S_RESP,
        S_GUARD
    } state_t;

    state_t            state, state_nx;
    logic [ID_W-1:0]   ptr;
    logic [ID_W-1:0]   pick;
    logic              pick_vld;
    logic              sel_wr;
    logic [15:0]       sel_addr;
    logic [7:0]        sel_wdata;
    logic [TMO_W-1:0]  tmo_cnt;
    logic [GRD_W-1:0]  grd_cnt;
    logic              err_flag;
    logic              tmo_hit;

    // Search upward from ptr+1 with wrap, so the last winner has lowest priority.
    always_comb begin
        int idx;
        logic [ID_W-1:0] cand;
        idx       = 0;
        cand      = '0;
        pick      = '0;
        pick_vld  = 1'b0;
        sel_wr    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = int'(ptr) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            cand = ID_W'(idx);
            if (!pick_vld && req[cand]) begin
                pick_vld = 1'b1;
                pick     = cand;
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (ID_W'(i) == pick) begin
                sel_wr    = req_wr[i];
                sel_addr  = req_addr[16*i +: 16];
                sel_wdata = req_wdata[8*i +: 8];
            end
        end
    end

    // The counter is cleared in ISSUE, so hitting TIMEOUT_CYCLES-2 here puts RESP
    // exactly TIMEOUT_CYCLES cycles after spi_start.
    assign tmo_hit = (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 2));

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:      if (pick_vld && !spi_busy) state_nx = S_ISSUE;
            S_ISSUE:     state_nx = S_WAIT_CLR;
            S_WAIT_CLR:  if (tmo_hit) state_nx = S_RESP;
                         else if (!spi_data_ready) state_nx = S_WAIT_DONE;
            S_WAIT_DONE: if (spi_data_ready || tmo_hit) state_nx = S_RESP;
            S_RESP:      state_nx = S_GUARD;
            S_GUARD:     if (grd_cnt == '0 && !spi_busy) state_nx = S_IDLE;
            default:     state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= S_IDLE;
            ptr            <= ID_W'(NUM_REQ - 1);
            tmo_cnt        <= '0;
            grd_cnt        <= '0;
            err_flag       <= 1'b0;
            rdata          <= '0;
            grant_id       <= '0;
            spi_write_read <= 1'b0;
            spi_data_in    <= '0;
        end else begin
            state <= state_nx;
            case (state)
                S_IDLE: begin
                    if (state_nx == S_ISSUE) begin
                        grant_id       <= pick;
                        ptr            <= pick;
                        spi_write_read <= sel_wr;
                        spi_data_in    <= {sel_addr, sel_wdata};
                    end
                end
                S_ISSUE: begin
                    tmo_cnt  <= '0;
                    err_flag <= 1'b0;
                end
                S_WAIT_CLR, S_WAIT_DONE: begin
                    tmo_cnt <= tmo_cnt + 1'b1;
                    if (state == S_WAIT_DONE && spi_data_ready && !spi_write_read)
                        rdata <= spi_data_out;
                    if (state_nx == S_RESP)
                        err_flag <= !(state == S_WAIT_DONE && spi_data_ready);
                end
                S_RESP: grd_cnt <= GRD_W'(GUARD_CYCLES);
                S_GUARD: if (grd_cnt != '0) grd_cnt <= grd_cnt - 1'b1;
                default: ;
            endcase
        end
    end

    assign spi_start = (state == S_ISSUE);
    assign err       = (state == S_RESP) && err_flag;
    assign ack       = (state == S_RESP) ? ({{(NUM_REQ-1){1'b0}}, 1'b1} << grant_id) : '0;

endmodule

// File: tb/tb_w5100s_access_arbiter.sv
// Directed bench for w5100s_access_arbiter with a behavioural SPI master model
// that supports normal, hung and stale-ready frames.
module tb_w5100s_access_arbiter;

    localparam int N     = 4;
    localparam int TMO   = 256;
    localparam int GRD   = 2;
    localparam int FRAME = 6;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N-1:0]    req = '0;
    logic [N-1:0]    req_wr = '0;
    logic [16*N-1:0] req_addr = '0;
    logic [8*N-1:0]  req_wdata = '0;
    logic [N-1:0]    ack;
    logic            err;
    logic [7:0]      rdata;
    logic [1:0]      grant_id;
    logic            spi_start;
    logic            spi_write_read;
    logic [23:0]     spi_data_in;
    logic            spi_busy = 1'b0;
    logic            spi_data_ready = 1'b0;
    logic [7:0]      spi_data_out = '0;

    int tests = 0;
    int fails = 0;

    w5100s_access_arbiter #(
        .NUM_REQ(N), .TIMEOUT_CYCLES(TMO), .GUARD_CYCLES(GRD)
    ) dut (
        .clk(clk), .rst(rst), .req(req), .req_wr(req_wr), .req_addr(req_addr),
        .req_wdata(req_wdata), .ack(ack), .err(err), .rdata(rdata), .grant_id(grant_id),
        .spi_start(spi_start), .spi_write_read(spi_write_read), .spi_data_in(spi_data_in),
        .spi_busy(spi_busy), .spi_data_ready(spi_data_ready), .spi_data_out(spi_data_out)
    );

    always #5 clk = ~clk;

    // SPI master model plus event monitor; read data is addr[7:0] ^ 8'hD1.
    int cyc = 0, start_cnt = 0, start_cyc = 0, rise_cyc = 0, ack_cnt = 0;
    int frame_left = 0, stale_left = 0, min_gap = 1000;
    bit hang = 1'b0, stale = 1'b0;
    logic [15:0] cur_addr = '0;

    always @(negedge clk) begin
        cyc++;
        if (ack != '0) ack_cnt++;
        if (spi_start) begin
            start_cnt++;
            if (cyc - rise_cyc - 1 < min_gap) min_gap = cyc - rise_cyc - 1;
            start_cyc  = cyc;
            cur_addr   = spi_data_in[23:8];
            spi_busy   = 1'b1;
            frame_left = FRAME;
            if (stale) stale_left = 3;
            else spi_data_ready = 1'b0;
        end else if (spi_busy && !hang) begin
            if (stale_left > 0) begin
                stale_left--;
                if (stale_left == 0) spi_data_ready = 1'b0;
            end
            frame_left--;
            if (frame_left == 0) begin
                spi_busy       = 1'b0;
                spi_data_ready = 1'b1;
                spi_data_out   = cur_addr[7:0] ^ 8'hD1;
                rise_cyc       = cyc;
            end
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic set_client(input int i, input bit wr, input logic [15:0] a, input logic [7:0] d);
        req_wr[i]          = wr;
        req_addr[16*i +: 16] = a;
        req_wdata[8*i +: 8]  = d;
    endtask

    task automatic wait_ack(input int limit, output logic [N-1:0] a, output logic e,
                            output logic [7:0] rd, output logic [1:0] gid, output int at);
        a = '0; e = 1'b0; rd = '0; gid = '0; at = -1;
        for (int i = 0; i < limit; i++) begin
            step();
            if (ack !== '0) begin
                a = ack; e = err; rd = rdata; gid = grant_id; at = cyc;
                return;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) step();
        tests++; if (ack !== 4'b0000) begin fails++; $display("FAIL reset_ack: got %b expected 0000", ack); end
        tests++; if (err !== 1'b0) begin fails++; $display("FAIL reset_err: got %b expected 0", err); end
        tests++; if (rdata !== 8'h00) begin fails++; $display("FAIL reset_rdata: got %h expected 00", rdata); end
        tests++; if (grant_id !== 2'd0) begin fails++; $display("FAIL reset_grant_id: got %0d expected 0", grant_id); end
        tests++; if (spi_start !== 1'b0) begin fails++; $display("FAIL reset_spi_start: got %b expected 0", spi_start); end
        tests++; if (spi_write_read !== 1'b0) begin fails++; $display("FAIL reset_write_read: got %b expected 0", spi_write_read); end
        tests++; if (spi_data_in !== 24'h0) begin fails++; $display("FAIL reset_data_in: got %h expected 000000", spi_data_in); end
        rst = 1'b0;
    endtask

    task automatic test_write();
        logic [N-1:0] a; logic e; logic [7:0] rd; logic [1:0] gid; int at, s0, a0;
        set_client(1, 1'b1, 16'h0019, 8'hA5);
        s0 = start_cnt; a0 = ack_cnt;
        req = 4'b0010;
        wait_ack(100, a, e, rd, gid, at);
        req = 4'b0000;
        tests++; if (a !== 4'b0010) begin fails++; $display("FAIL write_ack: got %b expected 0010", a); end
        tests++; if (e !== 1'b0) begin fails++; $display("FAIL write_err: got %b expected 0", e); end
        tests++; if (rd !== 8'h00) begin fails++; $display("FAIL write_rdata: got %h expected 00", rd); end
        tests++; if (gid !== 2'd1) begin fails++; $display("FAIL write_grant_id: got %0d expected 1", gid); end
        tests++; if (spi_data_in !== 24'h0019A5) begin fails++; $display("FAIL write_data_in: got %h expected 0019a5", spi_data_in); end
        tests++; if (spi_write_read !== 1'b1) begin fails++; $display("FAIL write_dir: got %b expected 1", spi_write_read); end
        tests++; if (at !== rise_cyc + 1) begin fails++; $display("FAIL write_ack_cycle: got %0d expected %0d", at, rise_cyc + 1); end
        repeat (10) step();
        tests++; if (start_cnt - s0 !== 1) begin fails++; $display("FAIL write_starts: got %0d expected 1", start_cnt - s0); end
        tests++; if (ack_cnt - a0 !== 1) begin fails++; $display("FAIL write_acks: got %0d expected 1", ack_cnt - a0); end
    endtask

    task automatic test_read();
        logic [N-1:0] a; logic e; logic [7:0] rd; logic [1:0] gid; int at;
        set_client(0, 1'b0, 16'h0080, 8'h00);
        req = 4'b0001;
        wait_ack(100, a, e, rd, gid, at);
        req = 4'b0000;
        tests++; if (a !== 4'b0001) begin fails++; $display("FAIL read_ack: got %b expected 0001", a); end
        tests++; if (rd !== 8'h51) begin fails++; $display("FAIL read_rdata: got %h expected 51", rd); end
        tests++; if (e !== 1'b0) begin fails++; $display("FAIL read_err: got %b expected 0", e); end
        tests++; if (spi_data_in !== 24'h008000) begin fails++; $display("FAIL read_data_in: got %h expected 008000", spi_data_in); end
        tests++; if (spi_write_read !== 1'b0) begin fails++; $display("FAIL read_dir: got %b expected 0", spi_write_read); end
        tests++; if (gid !== 2'd0) begin fails++; $display("FAIL read_grant_id: got %0d expected 0", gid); end
        repeat (10) step();
    endtask

    task automatic test_contention();
        logic [N-1:0] a; logic e; logic [7:0] rd; logic [1:0] gid; int at, s0, exp_id;
        logic [7:0] exp_rd [4];
        exp_rd[0] = 8'hC1; exp_rd[1] = 8'hF0; exp_rd[2] = 8'hE3; exp_rd[3] = 8'h92;
        rst = 1'b1; step(); rst = 1'b0;
        set_client(0, 1'b0, 16'h0010, 8'h00);
        set_client(1, 1'b0, 16'h0021, 8'h00);
        set_client(2, 1'b0, 16'h0032, 8'h00);
        set_client(3, 1'b0, 16'h0043, 8'h00);
        min_gap = 1000; s0 = start_cnt;
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            wait_ack(100, a, e, rd, gid, at);
            exp_id = k % 4;
            tests++; if (a !== 4'(1 << exp_id)) begin fails++; $display("FAIL contention_ack[%0d]: got %b expected %b", k, a, 4'(1 << exp_id)); end
            tests++; if (rd !== exp_rd[exp_id]) begin fails++; $display("FAIL contention_rdata[%0d]: got %h expected %h", k, rd, exp_rd[exp_id]); end
        end
        req = 4'b0000;
        repeat (10) step();
        tests++; if (start_cnt - s0 !== 5) begin fails++; $display("FAIL contention_starts: got %0d expected 5", start_cnt - s0); end
        tests++; if (min_gap < GRD) begin fails++; $display("FAIL contention_guard: got %0d idle cycles expected >= %0d", min_gap, GRD); end
    endtask

    task automatic test_timeout();
        logic [N-1:0] a; logic e; logic [7:0] rd; logic [1:0] gid; int at, s0;
        set_client(3, 1'b0, 16'h0042, 8'h00);
        hang = 1'b1;
        req = 4'b1000;
        wait_ack(400, a, e, rd, gid, at);
        req = 4'b0000;
        tests++; if (a !== 4'b1000) begin fails++; $display("FAIL timeout_ack: got %b expected 1000", a); end
        tests++; if (e !== 1'b1) begin fails++; $display("FAIL timeout_err: got %b expected 1", e); end
        tests++; if (rd !== 8'hC1) begin fails++; $display("FAIL timeout_rdata: got %h expected c1", rd); end
        tests++; if (at - start_cyc !== TMO) begin fails++; $display("FAIL timeout_latency: got %0d expected %0d", at - start_cyc, TMO); end
        set_client(1, 1'b1, 16'h0005, 8'h3C);
        s0 = start_cnt;
        req = 4'b0010;
        repeat (20) step();
        tests++; if (start_cnt !== s0) begin fails++; $display("FAIL timeout_busy_hold: got %0d starts expected 0", start_cnt - s0); end
        hang = 1'b0; spi_busy = 1'b0;
        wait_ack(100, a, e, rd, gid, at);
        req = 4'b0000;
        tests++; if (a !== 4'b0010) begin fails++; $display("FAIL timeout_next_ack: got %b expected 0010", a); end
        tests++; if (e !== 1'b0) begin fails++; $display("FAIL timeout_next_err: got %b expected 0", e); end
        tests++; if (rd !== 8'hC1) begin fails++; $display("FAIL timeout_next_rdata: got %h expected c1", rd); end
        repeat (10) step();
    endtask

    task automatic test_stale();
        logic [N-1:0] a; logic e; logic [7:0] rd; logic [1:0] gid; int at;
        stale = 1'b1;
        set_client(2, 1'b0, 16'h0077, 8'h00);
        req = 4'b0100;
        wait_ack(100, a, e, rd, gid, at);
        req = 4'b0000;
        stale = 1'b0;
        tests++; if (a !== 4'b0100) begin fails++; $display("FAIL stale_ack: got %b expected 0100", a); end
        tests++; if (at - start_cyc !== FRAME + 1) begin fails++; $display("FAIL stale_latency: got %0d expected %0d", at - start_cyc, FRAME + 1); end
        tests++; if (at !== rise_cyc + 1) begin fails++; $display("FAIL stale_ack_cycle: got %0d expected %0d", at, rise_cyc + 1); end
        tests++; if (rd !== 8'hA6) begin fails++; $display("FAIL stale_rdata: got %h expected a6", rd); end
        tests++; if (e !== 1'b0) begin fails++; $display("FAIL stale_err: got %b expected 0", e); end
        repeat (10) step();
    endtask

    task automatic test_reset_mid();
        logic [N-1:0] a; logic e; logic [7:0] rd; logic [1:0] gid; int at, s0, a0;
        hang = 1'b1;
        set_client(0, 1'b0, 16'h0099, 8'h00);
        s0 = start_cnt; a0 = ack_cnt;
        req = 4'b0001;
        for (int i = 0; i < 50 && start_cnt == s0; i++) step();
        tests++; if (start_cnt !== s0 + 1) begin fails++; $display("FAIL rstmid_start: got %0d starts expected 1", start_cnt - s0); end
        repeat (5) step();
        rst = 1'b1; step(); rst = 1'b0;
        req = 4'b0100;
        set_client(2, 1'b0, 16'h0055, 8'h00);
        tests++; if (ack !== 4'b0000) begin fails++; $display("FAIL rstmid_ack: got %b expected 0000", ack); end
        tests++; if (rdata !== 8'h00) begin fails++; $display("FAIL rstmid_rdata: got %h expected 00", rdata); end
        tests++; if (grant_id !== 2'd0) begin fails++; $display("FAIL rstmid_grant_id: got %0d expected 0", grant_id); end
        tests++; if (spi_data_in !== 24'h0) begin fails++; $display("FAIL rstmid_data_in: got %h expected 000000", spi_data_in); end
        tests++; if (spi_start !== 1'b0 || err !== 1'b0 || spi_write_read !== 1'b0) begin
            fails++; $display("FAIL rstmid_ctrl: got start=%b err=%b wr=%b expected 0 0 0", spi_start, err, spi_write_read);
        end
        repeat (10) step();
        tests++; if (start_cnt !== s0 + 1) begin fails++; $display("FAIL rstmid_busy_hold: got %0d starts expected 1", start_cnt - s0); end
        tests++; if (ack_cnt !== a0) begin fails++; $display("FAIL rstmid_no_ack: got %0d acks expected 0", ack_cnt - a0); end
        hang = 1'b0; spi_busy = 1'b0;
        wait_ack(100, a, e, rd, gid, at);
        req = 4'b0000;
        tests++; if (a !== 4'b0100) begin fails++; $display("FAIL rstmid_next_ack: got %b expected 0100", a); end
        tests++; if (gid !== 2'd2) begin fails++; $display("FAIL rstmid_next_grant: got %0d expected 2", gid); end
        tests++; if (rd !== 8'h84) begin fails++; $display("FAIL rstmid_next_rdata: got %h expected 84", rd); end
        tests++; if (e !== 1'b0) begin fails++; $display("FAIL rstmid_next_err: got %b expected 0", e); end
        repeat (5) step();
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_contention();
        test_timeout();
        test_stale();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

endmodule
